// File: rtl/peak_period_meter.sv
// peak_period_meter: captures peak/valley values per swing and measures the peak-to-peak period
//
// Ports:
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   datain     in   WIDTH  sample aligned with posen/negen (unsigned)
//   posen      in   1      strobe: datain is a local maximum
//   negen      in   1      strobe: datain is a local minimum
//   out_ready  in   1      consumer accepts result on out_valid&&out_ready
//   out_valid  out  1      result registers hold a new, unaccepted result
//   peak       out  WIDTH  peak closing the swing
//   valley     out  WIDTH  latest valley within the swing
//   ampl       out  WIDTH  peak - valley, saturated at 0
//   period     out  CNTW   cycles from opening peak to closing peak
//   ovf        out  1      sticky: a result was dropped under backpressure
//   timeout    out  1      pulse: period counter saturated, swing aborted
module peak_period_meter #(
    parameter int WIDTH = 16,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] datain,
    input  logic             posen,
    input  logic             negen,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] peak,
    output logic [WIDTH-1:0] valley,
    output logic [WIDTH-1:0] ampl,
    output logic [CNTW-1:0]  period,
    output logic             ovf,
    output logic             timeout
);
    typedef enum logic [1:0] {SEEK, ARMED, SWING} state_t;
    state_t state, state_nx;
    logic [CNTW-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] vl_r, vl_nx;
    logic pk_ev, vl_ev, cnt_max, issue, load;
    // simultaneous strobes are contradictory and treated as no event
    assign pk_ev   = posen & ~negen;
    assign vl_ev   = negen & ~posen;
    assign cnt_max = &cnt;
    assign load    = issue & (~out_valid | out_ready);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEEK;
            cnt   <= '0;
            vl_r  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            vl_r  <= vl_nx;
        end
    end
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        vl_nx    = vl_r;
        issue    = 1'b0;
        case (state)
            SEEK: begin
                state_nx = pk_ev ? ARMED : SEEK;
                cnt_nx   = pk_ev ? CNTW'(1) : '0;
            end
            ARMED, SWING: begin
                // a new peak wins over counter saturation
                if (pk_ev) begin
                    state_nx = ARMED;
                    cnt_nx   = CNTW'(1);
                    issue    = (state == SWING);
                end else if (cnt_max) begin
                    state_nx = SEEK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                    if (vl_ev) begin
                        state_nx = SWING;
                        vl_nx    = datain;
                    end
                end
            end
            default: begin
                state_nx = SEEK;
                cnt_nx   = '0;
            end
        endcase
    end
    always_comb timeout = (state != SEEK) & cnt_max & ~pk_ev;
    // a result arriving while an unaccepted one is held is dropped, not queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            peak      <= '0;
            valley    <= '0;
            ampl      <= '0;
            period    <= '0;
            ovf       <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                peak      <= datain;
                valley    <= vl_r;
                ampl      <= (datain >= vl_r) ? datain - vl_r : '0;
                period    <= cnt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (issue && !load) ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_peak_period_meter.sv
// tb_peak_period_meter: scoreboard bench for peak_period_meter with CNTW=4
module tb_peak_period_meter;
    typedef struct {
        logic [15:0] pk;
        logic [15:0] vl;
        logic [15:0] am;
        logic [3:0]  per;
    } res_t;
    logic        clk, rst_n, posen, negen, out_ready;
    logic [15:0] datain, peak, valley, ampl;
    logic [3:0]  period;
    logic        out_valid, ovf, timeout;
    int checks = 0;
    int errors = 0;
    res_t exp_q[$];
    peak_period_meter #(.WIDTH(16), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .datain(datain), .posen(posen), .negen(negen),
        .out_ready(out_ready), .out_valid(out_valid), .peak(peak), .valley(valley),
        .ampl(ampl), .period(period), .ovf(ovf), .timeout(timeout)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got peak=%0d valley=%0d ampl=%0d period=%0d, expected no result",
                         peak, valley, ampl, period);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if ({peak, valley, ampl, period} !== {e.pk, e.vl, e.am, e.per}) begin
                    errors++;
                    $display("FAIL result: got peak=%0d valley=%0d ampl=%0d period=%0d, expected peak=%0d valley=%0d ampl=%0d period=%0d",
                             peak, valley, ampl, period, e.pk, e.vl, e.am, e.per);
                end
            end
        end
    end
    task automatic drive(input logic p, input logic n, input logic [15:0] d);
        @(posedge clk);
        #1;
        posen  = p;
        negen  = n;
        datain = d;
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 16'd0);
    endtask
    task automatic push(input logic [15:0] pk, input logic [15:0] vl, input logic [15:0] am, input logic [3:0] per);
        res_t r;
        r.pk = pk; r.vl = vl; r.am = am; r.per = per;
        exp_q.push_back(r);
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        posen = 1'b0; negen = 1'b0; datain = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic test_reset();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 16'd100);
        drive(1'b0, 1'b1, 16'd10);
        drive(1'b1, 1'b0, 16'd80);
        drive(1'b0, 1'b1, 16'd5);
        drive(1'b1, 1'b0, 16'd90);
        drive(1'b0, 1'b1, 16'd3);
        drive(1'b0, 1'b0, 16'd0);
        checks++;
        if (!(out_valid === 1'b1 && ovf === 1'b1)) begin
            errors++;
            $display("FAIL pre_reset_state: got out_valid=%b ovf=%b, expected 1 1", out_valid, ovf);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, peak, valley, ampl, period, ovf, timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b pk=%0d vl=%0d am=%0d per=%0d ovf=%b to=%b, expected all 0",
                     out_valid, peak, valley, ampl, period, ovf, timeout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 1'b1, 16'd7);
        idle(1);
        drive(1'b1, 1'b0, 16'd40);
        idle(1);
        drive(1'b1, 1'b0, 16'd50);
        idle(2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL valley_after_reset: got out_valid=%b timeout=%b, expected 0 0", out_valid, timeout);
        end
    endtask
    task automatic test_basic();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd100);
        idle(4);
        drive(1'b0, 1'b1, 16'd20);
        idle(6);
        push(16'd110, 16'd20, 16'd90, 4'd12);
        drive(1'b1, 1'b0, 16'd110);
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_valid_t13: got %b, expected 1", out_valid);
        end
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid_t14: got %b, expected 0", out_valid);
        end
    endtask
    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        drive(1'b1, 1'b0, 16'd100);
        idle(1);
        drive(1'b0, 1'b1, 16'd10);
        idle(1);
        push(16'd80, 16'd10, 16'd70, 4'd4);
        drive(1'b1, 1'b0, 16'd80);
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || peak !== 16'd80 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_held: got v=%b pk=%0d ovf=%b, expected 1 80 0", out_valid, peak, ovf);
        end
        drive(1'b0, 1'b1, 16'd5);
        idle(1);
        drive(1'b1, 1'b0, 16'd90);
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if ({out_valid, peak, valley, ampl, period, ovf} !== {1'b1, 16'd80, 16'd10, 16'd70, 4'd4, 1'b1}) begin
            errors++;
            $display("FAIL bp_second_dropped: got v=%b pk=%0d vl=%0d am=%0d per=%0d ovf=%b, expected 1 80 10 70 4 1",
                     out_valid, peak, valley, ampl, period, ovf);
        end
        drive(1'b0, 1'b0, 16'd0);
        out_ready = 1'b1;
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL bp_after_accept: got out_valid=%b ovf=%b, expected 0 1", out_valid, ovf);
        end
    endtask
    task automatic test_double_peak();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd50);
        idle(3);
        drive(1'b1, 1'b0, 16'd60);
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL double_peak_no_result: got out_valid=%b, expected 0", out_valid);
        end
        drive(1'b0, 1'b1, 16'd10);
        idle(3);
        push(16'd70, 16'd10, 16'd60, 4'd6);
        drive(1'b1, 1'b0, 16'd70);
        idle(2);
    endtask
    task automatic test_timeout();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd30);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b0, 1'b0, 16'd0);
            @(negedge clk);
            checks++;
            if (timeout !== (k == 15)) begin
                errors++;
                $display("FAIL timeout_t%0d: got %b, expected %b", k, timeout, k == 15);
            end
        end
        drive(1'b0, 1'b1, 16'd2);
        idle(1);
        drive(1'b1, 1'b0, 16'd30);
        idle(1);
        drive(1'b1, 1'b0, 16'd40);
        idle(2);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_rearm_only: got out_valid=%b, expected 0", out_valid);
        end
    endtask
    task automatic test_edge_cases();
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 16'd100);
        idle(1);
        drive(1'b0, 1'b1, 16'd200);
        idle(1);
        drive(1'b1, 1'b1, 16'd5);
        drive(1'b0, 1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL both_strobes_ignored: got out_valid=%b, expected 0", out_valid);
        end
        idle(1);
        push(16'd150, 16'd200, 16'd0, 4'd7);
        drive(1'b1, 1'b0, 16'd150);
        idle(2);
    endtask
    initial begin
        rst_n = 1'b0;
        posen = 1'b0; negen = 1'b0; datain = '0; out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid, peak, valley, ampl, period, ovf, timeout} !== '0) begin
            errors++;
            $display("FAIL initial_reset: got v=%b pk=%0d ovf=%b to=%b, expected all 0", out_valid, peak, ovf, timeout);
        end
        test_reset();
        test_basic();
        test_backpressure();
        test_double_peak();
        test_timeout();
        test_edge_cases();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL results_outstanding: got %0d unconsumed, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
